// File: rtl/fir_beat_detector_if.sv
// fir_beat_detector_if
//   Bundles the sample stream coming from the FIR filter and the beat report
//   produced by fir_beat_detector.
//   master : drives sample_valid/sample and observes the beat report
//   slave  : consumes samples and drives beat, interval, interval_valid,
//            amplitude and no_signal
interface fir_beat_detector_if #(
    parameter int DATA_W = 20,
    parameter int CNT_W  = 16
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              beat;
    logic [CNT_W-1:0]  interval;
    logic              interval_valid;
    logic [DATA_W-1:0] amplitude;
    logic              no_signal;

    modport master (
        output sample_valid, sample,
        input  beat, interval, interval_valid, amplitude, no_signal
    );

    modport slave (
        input  sample_valid, sample,
        output beat, interval, interval_valid, amplitude, no_signal
    );
endinterface

// File: rtl/fir_beat_detector.sv
// fir_beat_detector
//   Peak detector for the pulse-oximetry FIR output stream. Alternates between
//   tracking a maximum (RISING) and a minimum (FALLING); an extremum is only
//   confirmed once the signal has moved HYST LSBs away from it. Each confirmed
//   peak outside the refractory window is reported as a beat together with the
//   number of accepted samples since the previous beat and the peak-to-trough
//   amplitude.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - slave side of fir_beat_detector_if (sample in, beat report out)
module fir_beat_detector #(
    parameter int DATA_W  = 20,
    parameter int CNT_W   = 16,
    parameter int HYST    = 64,
    parameter int REFRACT = 50,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_beat_detector_if.slave   bus
);

    typedef enum logic {
        RISING  = 1'b0,
        FALLING = 1'b1
    } state_t;

    // Hysteresis arithmetic is done one bit wider so neither peak-HYST nor
    // trough+HYST can wrap around.
    localparam logic [DATA_W:0]  HYST_EXT  = (DATA_W+1)'(HYST);
    localparam logic [CNT_W-1:0] REFRACT_C = CNT_W'(REFRACT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] trough_q, trough_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              have_ref_q, have_ref_d;
    logic              no_signal_q, no_signal_d;
    logic              beat_q, beat_d;
    logic [CNT_W-1:0]  interval_q, interval_d;
    logic              interval_valid_q, interval_valid_d;
    logic [DATA_W-1:0] amplitude_q, amplitude_d;

    logic [DATA_W:0]   sample_ext;
    logic [DATA_W:0]   peak_ext;
    logic [DATA_W:0]   peak_drop;
    logic [DATA_W:0]   trough_rise;
    logic [CNT_W-1:0]  cnt_inc;
    logic              sample_above_peak;
    logic              sample_below_trough;
    logic              peak_ge_hyst;
    logic              sample_le_drop;
    logic              sample_ge_rise;
    logic              refract_ok;
    logic              peak_confirm;
    logic              trough_confirm;
    logic              report;

    // Shared comparisons
    assign sample_ext          = {1'b0, bus.sample};
    assign peak_ext            = {1'b0, peak_q};
    assign peak_drop           = peak_ext - HYST_EXT;
    assign trough_rise         = {1'b0, trough_q} + HYST_EXT;
    assign sample_above_peak   = bus.sample > peak_q;
    assign sample_below_trough = bus.sample < trough_q;
    // peak_drop is only meaningful when it did not borrow, hence peak_ge_hyst.
    assign peak_ge_hyst        = peak_ext >= HYST_EXT;
    assign sample_le_drop      = sample_ext <= peak_drop;
    assign sample_ge_rise      = sample_ext >= trough_rise;
    assign cnt_inc             = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign refract_ok          = cnt_inc >= REFRACT_C;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RISING;
            peak_q           <= '0;
            trough_q         <= '0;
            cnt_q            <= '0;
            have_ref_q       <= 1'b0;
            no_signal_q      <= 1'b0;
            beat_q           <= 1'b0;
            interval_q       <= '0;
            interval_valid_q <= 1'b0;
            amplitude_q      <= '0;
        end else begin
            state_q          <= state_d;
            peak_q           <= peak_d;
            trough_q         <= trough_d;
            cnt_q            <= cnt_d;
            have_ref_q       <= have_ref_d;
            no_signal_q      <= no_signal_d;
            beat_q           <= beat_d;
            interval_q       <= interval_d;
            interval_valid_q <= interval_valid_d;
            amplitude_q      <= amplitude_d;
        end
    end

    // Next-state logic: extremum confirmation and beat decision
    always_comb begin
        state_d        = state_q;
        peak_confirm   = 1'b0;
        trough_confirm = 1'b0;
        report         = 1'b0;
        if (bus.sample_valid) begin
            if (state_q == RISING) begin
                if (!sample_above_peak && peak_ge_hyst && sample_le_drop) begin
                    peak_confirm = 1'b1;
                    state_d      = FALLING;
                    // After a timeout the refractory window no longer applies.
                    report       = refract_ok | ~have_ref_q | no_signal_q;
                end
            end else begin
                if (!sample_below_trough && sample_ge_rise) begin
                    trough_confirm = 1'b1;
                    state_d        = RISING;
                end
            end
        end
    end

    // Output/datapath logic: extremum tracking, counter and beat report
    always_comb begin
        peak_d           = peak_q;
        trough_d         = trough_q;
        cnt_d            = cnt_q;
        have_ref_d       = have_ref_q;
        no_signal_d      = no_signal_q;
        beat_d           = 1'b0;
        interval_d       = interval_q;
        interval_valid_d = 1'b0;
        amplitude_d      = amplitude_q;
        if (bus.sample_valid) begin
            cnt_d = cnt_inc;
            if (state_q == RISING) begin
                if (sample_above_peak) begin
                    peak_d = bus.sample;
                end
                // A suppressed peak still restarts trough tracking.
                if (peak_confirm) begin
                    trough_d = bus.sample;
                end
            end else begin
                if (sample_below_trough) begin
                    trough_d = bus.sample;
                end
                if (trough_confirm) begin
                    peak_d = bus.sample;
                end
            end
            if (report) begin
                beat_d           = 1'b1;
                // trough_q is still the trough that preceded this peak.
                amplitude_d      = peak_q - trough_q;
                interval_d       = cnt_inc;
                interval_valid_d = have_ref_q & ~no_signal_q;
                cnt_d            = '0;
                have_ref_d       = 1'b1;
                no_signal_d      = 1'b0;
            end else if (cnt_inc >= TIMEOUT_C) begin
                no_signal_d = 1'b1;
            end
        end
    end

    assign bus.beat           = beat_q;
    assign bus.interval       = interval_q;
    assign bus.interval_valid = interval_valid_q;
    assign bus.amplitude      = amplitude_q;
    assign bus.no_signal      = no_signal_q;

endmodule

// File: tb/tb_fir_beat_detector.sv
module tb_fir_beat_detector;

    localparam int DATA_W  = 20;
    localparam int CNT_W   = 16;
    localparam int HYST    = 8;
    localparam int REFRACT = 4;
    localparam int TIMEOUT = 32;

    logic clk;
    logic rst;

    int     checks;
    int     errors;
    longint last_beat_t;
    longint prev_beat_t;

    fir_beat_detector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    fir_beat_detector #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .HYST   (HYST),
        .REFRACT(REFRACT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] tri_val(input int k);
        int p;
        p = k % 20;
        return (p <= 10) ? DATA_W'(10 * p) : DATA_W'(10 * (20 - p));
    endfunction

    function automatic longint all_outputs();
        return longint'({bus.beat, bus.interval_valid, bus.no_signal, bus.interval, bus.amplitude});
    endfunction

    // One accepted sample followed by a check of the registered outputs.
    task automatic push(input logic [DATA_W-1:0] s, input bit eb, input int ei,
                        input bit eiv, input int ea, input bit ens);
        @(negedge clk);
        bus.sample       = s;
        bus.sample_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("sample=%0d beat=%0d interval=%0d ivalid=%0d amp=%0d no_signal=%0d",
                 s, bus.beat, bus.interval, bus.interval_valid, bus.amplitude, bus.no_signal);
        check_eq("beat", longint'(bus.beat), longint'(eb));
        check_eq("no_signal", longint'(bus.no_signal), longint'(ens));
        if (eb) begin
            check_eq("interval", longint'(bus.interval), longint'(ei));
            check_eq("interval_valid", longint'(bus.interval_valid), longint'(eiv));
            check_eq("amplitude", longint'(bus.amplitude), longint'(ea));
        end else begin
            check_eq("interval_valid_idle", longint'(bus.interval_valid), 0);
        end
        if (bus.beat) begin
            prev_beat_t = last_beat_t;
            last_beat_t = $time;
        end
    endtask

    // Cycles without sample_valid: beat must drop and interval must hold.
    task automatic idle(input int n, input int hold_int);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sample_valid = 1'b0;
            bus.sample       = DATA_W'($urandom);
            @(posedge clk);
            #1;
            check_eq("idle_beat", longint'(bus.beat | bus.interval_valid), 0);
            check_eq("idle_interval_hold", longint'(bus.interval), longint'(hold_int));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.sample_valid = 1'b0;
        #1;
        check_eq("reset_outputs", all_outputs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_beat_t = -1;
        prev_beat_t = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        checks           = 0;
        errors           = 0;
        last_beat_t      = -1;
        prev_beat_t      = -1;
        rst              = 1'b1;
        bus.sample       = '0;
        bus.sample_valid = 1'b0;

        // 1. Reset held with random activity: every output stays 0.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.sample       = DATA_W'($urandom);
            bus.sample_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_eq("reset_hold", all_outputs(), 0);
        end
        @(negedge clk);
        rst              = 1'b0;
        bus.sample_valid = 1'b0;

        // 2. Triangle wave at full rate: first beat interval 12 (not valid),
        //    then interval 20, amplitude 100.
        for (int k = 0; k < 72; k++) begin
            push(tri_val(k), (k % 20) == 11, (k == 11) ? 12 : 20, k != 11, 100, 1'b0);
        end

        // 3. Same wave, sample_valid every third cycle: beats 60 clocks apart.
        do_reset();
        for (int k = 0; k < 72; k++) begin
            push(tri_val(k), (k % 20) == 11, (k == 11) ? 12 : 20, k != 11, 100, 1'b0);
            idle(2, (k < 11) ? 0 : ((k < 31) ? 12 : 20));
            if ((k % 20) == 11 && k > 11) begin
                check_eq("gap_spacing", last_beat_t - prev_beat_t, 600);
            end
        end

        // 4. Hysteresis boundaries and timeout.
        do_reset();
        push(20'd0,   1'b0, 0, 1'b0, 0,   1'b0);
        push(20'd100, 1'b0, 0, 1'b0, 0,   1'b0);
        push(20'd93,  1'b0, 0, 1'b0, 0,   1'b0);  // 7 below peak: not enough
        push(20'd92,  1'b1, 4, 1'b0, 100, 1'b0);  // exactly 8 below: confirms
        push(20'd40,  1'b0, 0, 1'b0, 0,   1'b0);
        push(20'd47,  1'b0, 0, 1'b0, 0,   1'b0);  // 7 above trough: not enough
        push(20'd48,  1'b0, 0, 1'b0, 0,   1'b0);  // exactly 8 above: confirms trough
        // cnt is 3 here; small wiggles never confirm a peak, the 28th
        // wiggle sample (j=28) is the 32nd accepted sample since the beat.
        for (int j = 0; j < 40; j++) begin
            logic [DATA_W-1:0] w;
            case (j % 4)
                0:       w = 20'd50;
                1:       w = 20'd55;
                2:       w = 20'd50;
                default: w = 20'd49;
            endcase
            push(w, 1'b0, 0, 1'b0, 0, j >= 28);
        end
        // Drop to 0 confirms peak 55 against trough 40; no_signal forces
        // interval_valid low and then clears.
        push(20'd0, 1'b1, 44, 1'b0, 15, 1'b0);

        // 5. Refractory: a peak 2 samples after a beat is suppressed.
        push(20'd100, 1'b0, 0, 1'b0, 0,  1'b0);
        push(20'd0,   1'b0, 0, 1'b0, 0,  1'b0);  // cnt+1 = 2 < REFRACT
        push(20'd20,  1'b0, 0, 1'b0, 0,  1'b0);
        push(20'd30,  1'b0, 0, 1'b0, 0,  1'b0);
        push(20'd0,   1'b1, 5, 1'b1, 30, 1'b0);

        // 6. Asynchronous reset while the confirming sample is presented.
        do_reset();
        for (int k = 0; k < 51; k++) begin
            push(tri_val(k), (k % 20) == 11, (k == 11) ? 12 : 20, k != 11, 100, 1'b0);
        end
        @(negedge clk);
        bus.sample       = tri_val(51);
        bus.sample_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: interval=%0d amp=%0d beat=%0d", bus.interval, bus.amplitude, bus.beat);
        check_eq("async_rst_outputs", all_outputs(), 0);
        @(posedge clk);
        #1;
        check_eq("async_rst_no_beat", all_outputs(), 0);
        @(negedge clk);
        rst              = 1'b0;
        bus.sample_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            push(tri_val(k), k == 11, 12, 1'b0, 100, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
